// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control sequencer: instruction fields, opcodes and FSM states.
package alu_ctrl_pkg;

  localparam int unsigned INSTR_W = 24;
  localparam int unsigned IMM_W   = 10;

  localparam int unsigned OPC_MSB = 23;
  localparam int unsigned OPC_LSB = 19;
  localparam int unsigned RD_MSB  = 18;
  localparam int unsigned RD_LSB  = 16;
  localparam int unsigned RS_MSB  = 15;
  localparam int unsigned RS_LSB  = 13;
  localparam int unsigned RT_MSB  = 12;
  localparam int unsigned RT_LSB  = 10;
  localparam int unsigned IMM_MSB = 9;
  localparam int unsigned IMM_LSB = 0;

  typedef logic [4:0] opcode_t;
  typedef logic [2:0] state_t;

  localparam opcode_t OP_AND  = 5'b00000;
  localparam opcode_t OP_MAX  = 5'b00001;
  localparam opcode_t OP_ADD  = 5'b00010;
  localparam opcode_t OP_ADDI = 5'b00011;
  localparam opcode_t OP_SUB  = 5'b00100;
  localparam opcode_t OP_SGE  = 5'b00101;
  localparam opcode_t OP_ANDI = 5'b00111;
  localparam opcode_t OP_LW   = 5'b01000;
  localparam opcode_t OP_SW   = 5'b01001;
  localparam opcode_t OP_BEQ  = 5'b01011;
  localparam opcode_t OP_HALT = 5'b01111;

  localparam state_t ST_FETCH     = 3'd0;
  localparam state_t ST_DECODE    = 3'd1;
  localparam state_t ST_EXECUTE   = 3'd2;
  localparam state_t ST_MEM       = 3'd3;
  localparam state_t ST_WRITEBACK = 3'd4;
  localparam state_t ST_HALTED    = 3'd5;

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational opcode decoder: ALU control plus instruction-class flags.
module ctrl_decoder
  import alu_ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  output logic [4:0] alu_op,
  output logic       alu_src_imm,
  output logic       is_rtype,
  output logic       is_itype,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_halt,
  output logic       is_illegal
);

  always_comb begin
    alu_op      = '0;
    alu_src_imm = 1'b0;
    is_rtype    = 1'b0;
    is_itype    = 1'b0;
    is_load     = 1'b0;
    is_store    = 1'b0;
    is_branch   = 1'b0;
    is_halt     = 1'b0;
    is_illegal  = 1'b0;
    case (opcode)
      OP_AND, OP_MAX, OP_ADD, OP_SUB, OP_SGE: begin
        alu_op   = opcode;
        is_rtype = 1'b1;
      end
      OP_ADDI, OP_ANDI: begin
        alu_op      = opcode;
        alu_src_imm = 1'b1;
        is_itype    = 1'b1;
      end
      // Memory ops use the ALU to form rs + imm as the address.
      OP_LW: begin
        alu_op      = opcode;
        alu_src_imm = 1'b1;
        is_load     = 1'b1;
      end
      OP_SW: begin
        alu_op      = opcode;
        alu_src_imm = 1'b1;
        is_store    = 1'b1;
      end
      OP_BEQ: begin
        alu_op    = opcode;
        is_branch = 1'b1;
      end
      OP_HALT: is_halt = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_sequencer.sv
// Multi-cycle control sequencer: fetch/decode/execute/mem/writeback FSM, PC and instruction latch.
module alu_ctrl_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned       DATA_W      = 24,
  parameter logic [DATA_W-1:0] RESET_PC    = '0,
  parameter int unsigned       MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  output logic               instr_req,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic [DATA_W-1:0]  pc,
  output logic [4:0]         alu_op,
  output logic               alu_src_imm,
  input  logic               alu_zero,
  output logic [2:0]         rs_sel,
  output logic [2:0]         rt_sel,
  output logic [2:0]         rd_sel,
  output logic [DATA_W-1:0]  imm_ext,
  output logic               reg_write,
  output logic               mem_to_reg,
  output logic               mem_read,
  output logic               mem_write,
  input  logic               mem_ready,
  output logic               halted,
  output logic               illegal_op,
  output logic               mem_fault
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [DATA_W-1:0]    r_pc;
  logic [DATA_W-1:0]    w_pc_nxt;
  logic [INSTR_W-1:0]   r_instr;
  logic [INSTR_W-1:0]   w_instr_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic                 r_fault;
  logic                 w_fault_nxt;

  logic [4:0]           w_alu_op;
  logic                 w_alu_src_imm;
  logic                 w_is_rtype;
  logic                 w_is_itype;
  logic                 w_is_load;
  logic                 w_is_store;
  logic                 w_is_branch;
  logic                 w_is_halt;
  logic                 w_is_illegal;
  logic [DATA_W-1:0]    w_imm_ext;

  // Decode always works from the latched word, so control outputs never see the instr bus.
  ctrl_decoder u_decoder (
    .opcode      (r_instr[OPC_MSB:OPC_LSB]),
    .alu_op      (w_alu_op),
    .alu_src_imm (w_alu_src_imm),
    .is_rtype    (w_is_rtype),
    .is_itype    (w_is_itype),
    .is_load     (w_is_load),
    .is_store    (w_is_store),
    .is_branch   (w_is_branch),
    .is_halt     (w_is_halt),
    .is_illegal  (w_is_illegal)
  );

  assign w_imm_ext = {{(DATA_W - IMM_W){r_instr[IMM_MSB]}}, r_instr[IMM_MSB:IMM_LSB]};

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_cnt_nxt   = r_cnt;
    w_fault_nxt = r_fault;
    case (r_state)
      ST_FETCH: begin
        if (instr_valid) begin
          w_instr_nxt = instr;
          w_pc_nxt    = r_pc + DATA_W'(1);
          w_state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (w_is_halt) begin
          w_state_nxt = ST_HALTED;
        end else if (w_is_illegal) begin
          w_state_nxt = ST_FETCH;
        end else begin
          w_state_nxt = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        w_cnt_nxt = '0;
        if (w_is_load || w_is_store) begin
          w_state_nxt = ST_MEM;
        end else if (w_is_branch) begin
          // Branch target is relative to the already-incremented PC.
          if (alu_zero) begin
            w_pc_nxt = r_pc + w_imm_ext;
          end
          w_state_nxt = ST_FETCH;
        end else if (w_is_rtype || w_is_itype) begin
          w_state_nxt = ST_WRITEBACK;
        end else begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_MEM: begin
        // A ready in the final allowed cycle still wins over the timeout.
        if (mem_ready) begin
          w_state_nxt = w_is_load ? ST_WRITEBACK : ST_FETCH;
        end else if (r_cnt == CNT_LAST) begin
          w_fault_nxt = 1'b1;
          w_state_nxt = ST_HALTED;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_WRITEBACK: w_state_nxt = ST_FETCH;
      ST_HALTED:    w_state_nxt = ST_HALTED;
      default:      w_state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_FETCH;
      r_pc    <= RESET_PC;
      r_instr <= '0;
      r_cnt   <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_fault <= w_fault_nxt;
    end
  end

  // Strobes are pure state decode, so reset drops them without waiting for a clock.
  assign instr_req   = (r_state == ST_FETCH);
  assign reg_write   = (r_state == ST_WRITEBACK);
  assign mem_to_reg  = (r_state == ST_WRITEBACK) && w_is_load;
  assign mem_read    = (r_state == ST_MEM) && w_is_load;
  assign mem_write   = (r_state == ST_MEM) && w_is_store;
  assign halted      = (r_state == ST_HALTED);
  assign illegal_op  = (r_state == ST_DECODE) && w_is_illegal;
  assign mem_fault   = r_fault;

  assign pc          = r_pc;
  assign alu_op      = w_alu_op;
  assign alu_src_imm = w_alu_src_imm;
  assign rd_sel      = r_instr[RD_MSB:RD_LSB];
  assign rs_sel      = r_instr[RS_MSB:RS_LSB];
  assign rt_sel      = r_instr[RT_MSB:RT_LSB];
  assign imm_ext     = w_imm_ext;

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// Self-checking bench: per-instruction expected output trace, checked every cycle at negedge.
module tb_alu_ctrl_sequencer;

  localparam int TO = 15;
  localparam logic [4:0] AND_ = 5'h00, MAX_ = 5'h01, ADD_ = 5'h02, ADDI_ = 5'h03;
  localparam logic [4:0] SUB_ = 5'h04, SGE_ = 5'h05, ANDI_ = 5'h07, LW_ = 5'h08;
  localparam logic [4:0] SW_ = 5'h09, BEQ_ = 5'h0B, HALT_ = 5'h0F;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_req, instr_valid, alu_src_imm, alu_zero;
  logic [23:0] instr, pc, imm_ext;
  logic [4:0]  alu_op;
  logic [2:0]  rs_sel, rt_sel, rd_sel;
  logic        reg_write, mem_to_reg, mem_read, mem_write, mem_ready;
  logic        halted, illegal_op, mem_fault;

  always #5 clk = ~clk;

  alu_ctrl_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .instr_req   (instr_req),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc          (pc),
    .alu_op      (alu_op),
    .alu_src_imm (alu_src_imm),
    .alu_zero    (alu_zero),
    .rs_sel      (rs_sel),
    .rt_sel      (rt_sel),
    .rd_sel      (rd_sel),
    .imm_ext     (imm_ext),
    .reg_write   (reg_write),
    .mem_to_reg  (mem_to_reg),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_ready   (mem_ready),
    .halted      (halted),
    .illegal_op  (illegal_op),
    .mem_fault   (mem_fault)
  );

  typedef struct packed {
    logic        instr_req;
    logic [23:0] pc;
    logic [4:0]  alu_op;
    logic        src_imm;
    logic        chk_op;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [23:0] imm;
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_read;
    logic        mem_write;
    logic        halted;
    logic        illegal_op;
    logic        mem_fault;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        ce;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [23:0] m_pc, m_ins;
  logic        m_fault, m_halted;
  int          rd_cycles = 0, wr_cycles = 0, rw_cycles = 0, ill_cycles = 0, m2r_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic bit is_legal(input logic [4:0] op);
    return op inside {AND_, MAX_, ADD_, SUB_, SGE_, ADDI_, ANDI_, LW_, SW_, BEQ_, HALT_};
  endfunction

  function automatic exp_t base_exp();
    exp_t e;
    logic [4:0] op;
    e = '0;
    op = m_ins[23:19];
    e.pc        = m_pc;
    e.rd        = m_ins[18:16];
    e.rs        = m_ins[15:13];
    e.rt        = m_ins[12:10];
    e.imm       = 24'($signed(m_ins[9:0]));
    e.alu_op    = op;
    e.src_imm   = op inside {ADDI_, ANDI_, LW_, SW_};
    e.chk_op    = is_legal(op) && (op != HALT_);
    e.halted    = m_halted;
    e.mem_fault = m_fault;
    return e;
  endfunction

  function automatic logic rbit();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic logic [23:0] junk();
    return 24'($urandom);
  endfunction

  // Compare process: one expected record per cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ce = exp_q.pop_front();
      chk("instr_req", 32'(instr_req), 32'(ce.instr_req));
      chk("pc", 32'(pc), 32'(ce.pc));
      chk("rd_sel", 32'(rd_sel), 32'(ce.rd));
      chk("rs_sel", 32'(rs_sel), 32'(ce.rs));
      chk("rt_sel", 32'(rt_sel), 32'(ce.rt));
      chk("imm_ext", 32'(imm_ext), 32'(ce.imm));
      chk("reg_write", 32'(reg_write), 32'(ce.reg_write));
      chk("mem_to_reg", 32'(mem_to_reg), 32'(ce.mem_to_reg));
      chk("mem_read", 32'(mem_read), 32'(ce.mem_read));
      chk("mem_write", 32'(mem_write), 32'(ce.mem_write));
      chk("halted", 32'(halted), 32'(ce.halted));
      chk("illegal_op", 32'(illegal_op), 32'(ce.illegal_op));
      chk("mem_fault", 32'(mem_fault), 32'(ce.mem_fault));
      if (ce.chk_op) begin
        chk("alu_op", 32'(alu_op), 32'(ce.alu_op));
        chk("alu_src_imm", 32'(alu_src_imm), 32'(ce.src_imm));
      end
    end
  end

  always @(negedge clk) begin
    if (mem_read)   rd_cycles++;
    if (mem_write)  wr_cycles++;
    if (reg_write)  rw_cycles++;
    if (illegal_op) ill_cycles++;
    if (mem_to_reg) m2r_cycles++;
  end

  // Entered at posedge+1; drives the cycle's inputs and expected outputs.
  task automatic step(input logic v, input logic [23:0] ins, input logic z, input logic rdy,
                      input exp_t e);
    reset = 1'b0;
    instr_valid = v;
    instr = ins;
    alu_zero = z;
    mem_ready = rdy;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [23:0] ins, input int vdelay, input logic zero,
                           input int rdelay, input int abort_at);
    exp_t e;
    logic [4:0] op;
    op = ins[23:19];
    if (m_halted) begin
      for (int i = 0; i < 3; i++) begin
        e = base_exp();
        step(1'b1, ins, rbit(), rbit(), e);
      end
      return;
    end
    for (int d = 0; d <= vdelay; d++) begin
      e = base_exp();
      e.instr_req = 1'b1;
      step(d == vdelay, (d == vdelay) ? ins : junk(), rbit(), rbit(), e);
    end
    m_ins = ins;
    m_pc  = m_pc + 24'd1;
    e = base_exp();
    e.illegal_op = !is_legal(op);
    step(rbit(), junk(), rbit(), rbit(), e);
    if (op == HALT_) begin
      m_halted = 1'b1;
      for (int i = 0; i < 4; i++) begin
        e = base_exp();
        step(1'b1, junk(), rbit(), rbit(), e);
      end
      return;
    end
    if (!is_legal(op)) return;
    e = base_exp();
    step(rbit(), junk(), zero, rbit(), e);
    if (op == BEQ_) begin
      if (zero) m_pc = m_pc + 24'($signed(ins[9:0]));
      return;
    end
    if (op == LW_ || op == SW_) begin
      for (int k = 0; k < TO; k++) begin
        if (k == abort_at) return;
        e = base_exp();
        e.mem_read  = (op == LW_);
        e.mem_write = (op == SW_);
        step(rbit(), junk(), rbit(), k == rdelay, e);
        if (k == rdelay) break;
        if (k == TO - 1) begin
          m_fault  = 1'b1;
          m_halted = 1'b1;
          e = base_exp();
          step(1'b1, junk(), rbit(), rbit(), e);
          return;
        end
      end
      if (op == SW_) return;
    end
    e = base_exp();
    e.reg_write  = 1'b1;
    e.mem_to_reg = (op == LW_);
    step(rbit(), junk(), rbit(), rbit(), e);
  endtask

  // Entered at posedge+1; asserts reset mid-cycle and checks outputs before any edge.
  task automatic async_reset(input bit expect_read);
    #2;
    if (expect_read) chk("mem_read_before_reset", 32'(mem_read), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_reg_write", 32'(reg_write), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_mem_fault", 32'(mem_fault), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_imm_ext", 32'(imm_ext), 32'd0);
    instr_valid = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    m_pc = '0;
    m_ins = '0;
    m_fault = 1'b0;
    m_halted = 1'b0;
  endtask

  function automatic logic [23:0] rand_instr();
    logic [4:0] op;
    int sel;
    sel = int'($urandom_range(0, 10));
    case (sel)
      0: op = AND_;
      1: op = MAX_;
      2: op = ADD_;
      3: op = SUB_;
      4: op = SGE_;
      5: op = ADDI_;
      6: op = ANDI_;
      7: op = LW_;
      8: op = SW_;
      9: op = BEQ_;
      default: begin
        op = 5'h1F;
        for (int i = 0; i < 20; i++) begin
          op = 5'($urandom);
          if (!is_legal(op)) break;
        end
        if (is_legal(op)) op = 5'h1F;
      end
    endcase
    return {op, 19'($urandom)};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, s1, s2;
    int rdl;
    reset = 1'b1;
    instr_valid = 1'b1;
    instr = 24'h10A000;
    alu_zero = 1'b0;
    mem_ready = 1'b0;
    m_pc = '0;
    m_ins = '0;
    m_fault = 1'b0;
    m_halted = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", 32'(pc), 32'd0);
    chk("reset_reg_write", 32'(reg_write), 32'd0);
    chk("reset_mem_fault", 32'(mem_fault), 32'd0);
    chk("reset_halted", 32'(halted), 32'd0);
    chk("reset_alu_op", 32'(alu_op), 32'd0);

    // ADD straight out of reset with valid already high.
    s0 = rw_cycles;
    run_instr(24'h10A000, 0, 1'b0, 0, -1);
    chk("add_pc", 32'(pc), 32'd1);
    chk("add_alu_op", 32'(alu_op), 32'h02);
    chk("add_reg_write_cycles", 32'(rw_cycles - s0), 32'd1);

    run_instr({ADDI_, 3'd3, 3'd1, 3'd0, 10'h3FF}, 1, 1'b0, 0, -1);
    chk("addi_imm_ext", 32'(imm_ext), 32'hFFFFFF);
    chk("addi_src_imm", 32'(alu_src_imm), 32'd1);

    run_instr({ADD_, 3'd1, 3'd2, 3'd3, 10'h000}, 0, 1'b0, 0, -1);
    s0 = rw_cycles;
    run_instr({BEQ_, 3'd0, 3'd1, 3'd2, 10'd5}, 0, 1'b1, 0, -1);
    chk("beq_taken_pc", 32'(pc), 32'd9);
    run_instr({BEQ_, 3'd0, 3'd1, 3'd2, 10'h3F9}, 0, 1'b1, 0, -1);
    chk("beq_back_pc", 32'(pc), 32'd3);
    run_instr({BEQ_, 3'd0, 3'd1, 3'd2, 10'd5}, 2, 1'b0, 0, -1);
    chk("beq_not_taken_pc", 32'(pc), 32'd4);
    chk("beq_no_reg_write", 32'(rw_cycles - s0), 32'd0);

    s0 = rd_cycles; s1 = m2r_cycles;
    run_instr({LW_, 3'd4, 3'd1, 3'd0, 10'h010}, 0, 1'b0, 3, -1);
    chk("lw_read_cycles", 32'(rd_cycles - s0), 32'd4);
    chk("lw_mem_to_reg_cycles", 32'(m2r_cycles - s1), 32'd1);

    s0 = rd_cycles;
    run_instr({LW_, 3'd5, 3'd2, 3'd0, 10'h001}, 0, 1'b0, TO - 1, -1);
    chk("lw_last_cycle_ready_reads", 32'(rd_cycles - s0), 32'd15);
    chk("lw_last_cycle_no_fault", 32'(mem_fault), 32'd0);

    s0 = ill_cycles; s1 = rw_cycles; s2 = rd_cycles + wr_cycles;
    run_instr({5'b11111, 19'h12345}, 0, 1'b0, 0, -1);
    chk("illegal_pulse_cycles", 32'(ill_cycles - s0), 32'd1);
    chk("illegal_no_reg_write", 32'(rw_cycles - s1), 32'd0);
    chk("illegal_no_mem", 32'(rd_cycles + wr_cycles - s2), 32'd0);
    chk("illegal_back_to_fetch", 32'(instr_req), 32'd1);

    for (int n = 0; n < 150; n++) begin
      rdl = ($urandom_range(0, 9) == 0) ? TO - 1 : int'($urandom_range(0, 5));
      run_instr(rand_instr(), int'($urandom_range(0, 2)), rbit(), rdl, -1);
    end

    // Reset in the middle of a load.
    run_instr({LW_, 3'd1, 3'd1, 3'd1, 10'h004}, 0, 1'b0, 99, 2);
    exp_q.delete();
    async_reset(1'b1);
    run_instr(24'h10A000, 0, 1'b0, 0, -1);
    chk("post_reset_pc", 32'(pc), 32'd1);

    s0 = wr_cycles;
    run_instr({SW_, 3'd0, 3'd2, 3'd3, 10'h020}, 0, 1'b0, 99, -1);
    chk("sw_timeout_fault", 32'(mem_fault), 32'd1);
    chk("sw_timeout_halted", 32'(halted), 32'd1);
    chk("sw_write_cycles", 32'(wr_cycles - s0), 32'd15);
    run_instr(24'h10A000, 0, 1'b0, 0, -1);
    chk("fault_sticky", 32'(mem_fault), 32'd1);

    async_reset(1'b0);
    run_instr(24'h780000, 0, 1'b0, 0, -1);
    chk("halt_halted", 32'(halted), 32'd1);
    run_instr(24'h10A000, 0, 1'b0, 0, -1);
    chk("halt_stays", 32'(halted), 32'd1);
    chk("halt_pc", 32'(pc), 32'd1);
    chk("halt_no_req", 32'(instr_req), 32'd0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
